serial_number_transmitter: RTL and testbench
============================================

SERIAL_NUMBER_TRANSMITTER -- requirements
Module: serial_number_transmitter

Interface
REQ-001 The module SHALL have parameter WIDTH, default 8, giving the bit width of the parallel number; legal range WIDTH >= 2.
REQ-002 The module SHALL have port clk  input  1  single clock; all state updates on rising edge.
REQ-003 The module SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 The module SHALL have port in_valid  input  1  parallel number offered.
REQ-005 The module SHALL have port in_ready  output  1  block idle and able to accept a number.
REQ-006 The module SHALL have port in_data  input  WIDTH  number to serialize, unsigned.
REQ-007 The module SHALL have port out_valid  output  1  new_bit carries a valid bit.
REQ-008 The module SHALL have port out_ready  input  1  downstream accepts the current bit.
REQ-009 The module SHALL have port new_bit  output  1  current serial bit, MSB first.
REQ-010 The module SHALL have port first  output  1  current bit is the MSB of a new number; receiver clears its remainder on it.
REQ-011 The module SHALL have port last  output  1  current bit is the LSB of the number.
REQ-012 The module SHALL have port exp_rem  output  3  registered remainder mod 5 of the bits transferred so far.
REQ-013 The module SHALL have port exp_div_by_5  output  1  high when exp_rem == 0.

Function
REQ-014 The FSM SHALL have two states: IDLE and SEND.
REQ-015 in_ready SHALL be 1 in IDLE and 0 in SEND, with no combinational path from in_valid or out_ready.
REQ-016 Accept: on an edge with in_valid && in_ready, the block SHALL load in_data into the shift register, load the bit counter with WIDTH-1, clear exp_rem to 0, and enter SEND.
REQ-017 Latency: out_valid SHALL go high in the cycle directly after accept, with new_bit = in_data[WIDTH-1] and first = 1.
REQ-018 A bit SHALL transfer on an edge with out_valid && out_ready; the block SHALL then shift to the next lower bit and decrement the counter.
REQ-019 first SHALL be 1 only for bit WIDTH-1, and last SHALL be 1 only when the counter is 0.
REQ-020 Backpressure: while out_valid && !out_ready, new_bit, first, last and exp_rem SHALL hold unchanged.
REQ-021 On each bit transfer, exp_rem SHALL update to (2*exp_rem + new_bit) mod 5 using the table 0->0/1, 1->2/3, 2->4/0, 3->1/2, 4->3/4 (next state for bit 0 / bit 1).
REQ-022 exp_rem SHALL never take values 5..7.
REQ-023 On the transfer of the bit with last = 1, the block SHALL return to IDLE; out_valid SHALL be 0 and in_ready 1 in the next cycle.
REQ-024 There is no back-to-back acceptance, so the minimum gap between numbers SHALL be one idle cycle.
REQ-025 After the final bit, exp_rem and exp_div_by_5 SHALL hold the remainder of the full number until the next accept.
REQ-026 in_valid asserted during SEND SHALL be ignored, with no effect on the data in flight.
REQ-027 Simultaneous in_valid and the last-bit transfer SHALL NOT accept the new number in that cycle; it is accepted one cycle later in IDLE.
REQ-028 exp_div_by_5 SHALL be a pure decode of exp_rem.

Reset
REQ-029 While rst_n = 0, all registers SHALL clear immediately regardless of clk: state = IDLE, shift register = 0, counter = 0, exp_rem = 0.
REQ-030 Outputs during reset SHALL be: in_ready = 1, out_valid = 0, new_bit = 0, first = 0, last = 0, exp_rem = 0, exp_div_by_5 = 1.
REQ-031 Reset asserted mid-number SHALL abort it with no completion, and the remaining bits SHALL be discarded.

Structure
REQ-032 A shared package SHALL hold the state enum (IDLE, SEND) and the mod-5 next-remainder function.
REQ-033 The remainder update SHALL be one sub-module, mod5_remainder_tracker, with inputs clk, rst_n, clear, step, bit and output rem[2:0].
REQ-034 The counter width SHALL be $clog2(WIDTH).

Verification
REQ-035 Scenario, WIDTH=8, in_data=8'hA5, out_ready held 1: bits SHALL be 1,0,1,0,0,1,0,1, exp_rem after each bit SHALL be 1,2,0,0,0,1,2,0, final exp_div_by_5 = 1, and there SHALL be 8 consecutive out_valid cycles.
REQ-036 Scenario, in_data=8'h07: bits SHALL be 0,0,0,0,0,1,1,1, exp_rem SHALL be 0,0,0,0,0,1,3,2, and final exp_div_by_5 = 0.
REQ-037 Scenario, 8'hA5 with out_ready low for 3 cycles at bit index 5: new_bit=1 and exp_rem=0 SHALL hold, and the final result SHALL be unchanged.
REQ-038 Scenario, in_valid held high throughout with 8'h07 then 8'hA5: the second number SHALL be accepted only after last, leaving one idle cycle, and the first bit of 8'hA5 SHALL have first=1 and exp_rem reset to 0.
REQ-039 Scenario, rst_n pulsed low mid-edge at bit 3: outputs SHALL drop to reset values asynchronously, with in_ready=1 and no further out_valid.
REQ-040 Scenario, stream new_bit/out_valid into serial_divisibility_by_5_using_fsm, with its reset driven on first: its div_by_5 SHALL equal exp_div_by_5 after every bit.

Source files
------------

// File: rtl/serial_number_transmitter_pkg.sv
// Shared types and the mod-5 remainder step used by the serial number transmitter.
package serial_number_transmitter_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Remainder after appending one bit below the current value: (2*rem + b) mod 5.
  function automatic logic [2:0] mod5_next(input logic [2:0] rem, input logic b);
    logic [2:0] nxt;
    unique case (rem)
      3'd0:    nxt = b ? 3'd1 : 3'd0;
      3'd1:    nxt = b ? 3'd3 : 3'd2;
      3'd2:    nxt = b ? 3'd0 : 3'd4;
      3'd3:    nxt = b ? 3'd2 : 3'd1;
      3'd4:    nxt = b ? 3'd4 : 3'd3;
      default: nxt = 3'd0;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/serial_number_transmitter_tracker.sv
// Running mod-5 remainder of an MSB-first bit stream; cleared at the start of each number.
module mod5_remainder_tracker
  import serial_number_transmitter_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clear,
  input  logic       step,
  input  logic       bit_in,
  output logic [2:0] rem
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rem <= 3'd0;
    else if (clear) rem <= 3'd0;
    else if (step)  rem <= mod5_next(rem, bit_in);
  end

endmodule

// File: rtl/serial_number_transmitter.sv
// Serializes a WIDTH-bit number MSB first with valid/ready handshakes on both sides,
// tracking the mod-5 remainder of the bits already sent.
module serial_number_transmitter
  import serial_number_transmitter_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             new_bit,
  output logic             first,
  output logic             last,
  output logic [2:0]       exp_rem,
  output logic             exp_div_by_5
);

  localparam int CW = $clog2(WIDTH);

  state_t           state, state_nxt;
  logic [WIDTH-1:0] sr;
  logic [CW-1:0]    cnt;
  logic             accept, xfer;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Handshake outputs depend only on state, so no combinational path from the inputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    xfer      = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept    = 1'b1;
          state_nxt = SEND;
        end
      end
      SEND: begin
        out_valid = 1'b1;
        if (out_ready) begin
          xfer = 1'b1;
          if (cnt == CW'(0)) state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr  <= '0;
      cnt <= '0;
    end else if (accept) begin
      sr  <= in_data;
      cnt <= CW'(WIDTH - 1);
    end else if (xfer) begin
      sr  <= {sr[WIDTH-2:0], 1'b0};
      cnt <= cnt - 1'b1;
    end
  end

  assign new_bit = out_valid & sr[WIDTH-1];
  assign first   = out_valid && (cnt == CW'(WIDTH - 1));
  assign last    = out_valid && (cnt == CW'(0));

  mod5_remainder_tracker u_rem (
    .clk    (clk),
    .rst_n  (rst_n),
    .clear  (accept),
    .step   (xfer),
    .bit_in (new_bit),
    .rem    (exp_rem)
  );

  assign exp_div_by_5 = (exp_rem == 3'd0);

endmodule

// File: tb/tb_serial_number_transmitter.sv
// Directed bench for serial_number_transmitter: hand-computed bit/remainder tables plus
// an independent arithmetic mod-5 receiver model reset on first.
module tb_serial_number_transmitter;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] in_data;
  logic         out_valid;
  logic         out_ready;
  logic         new_bit;
  logic         first;
  logic         last;
  logic [2:0]   exp_rem;
  logic         exp_div_by_5;

  int n_chk = 0;
  int n_err = 0;
  int ref_rem = 0;

  always #5 clk = ~clk;

  serial_number_transmitter #(.WIDTH(W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .new_bit      (new_bit),
    .first        (first),
    .last         (last),
    .exp_rem      (exp_rem),
    .exp_div_by_5 (exp_div_by_5)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  // Entered and left at a negedge with the DUT idle. rems holds the remainder after
  // bit i at [3*i +: 3]; bits holds the expected stream MSB first.
  task automatic run_num(input logic [7:0] d, input logic [7:0] bits, input logic [23:0] rems,
                         input logic div_exp, input int stall_at, input int stall_n,
                         input logic hold, input logic [7:0] nxt);
    logic [2:0] prev;
    in_valid = 1'b1;
    in_data  = d;
    chk("acc_rdy", in_ready, 1);
    @(negedge clk);
    if (!hold) in_valid = 1'b0;
    else       in_data  = nxt;
    prev = 3'd0;
    for (int i = 0; i < 8; i++) begin
      chk("ovld", out_valid, 1);
      chk("rdy_busy", in_ready, 0);
      chk("bit", new_bit, bits[7-i]);
      chk("first", first, i == 0);
      chk("last", last, i == 7);
      chk("rem_pre", exp_rem, prev);
      if (first) ref_rem = 0;
      if (i == stall_at) begin
        out_ready = 1'b0;
        repeat (stall_n) begin
          @(negedge clk);
          chk("st_vld", out_valid, 1);
          chk("st_bit", new_bit, bits[7-i]);
          chk("st_rem", exp_rem, prev);
          chk("st_first", first, i == 0);
          chk("st_last", last, i == 7);
        end
        out_ready = 1'b1;
      end
      ref_rem = (2 * ref_rem + int'(new_bit)) % 5;
      @(negedge clk);
      prev = rems[3*i +: 3];
      chk("rem", exp_rem, prev);
      chk("div_ref", exp_div_by_5, ref_rem == 0);
    end
    chk("done_vld", out_valid, 0);
    chk("done_rdy", in_ready, 1);
    chk("div", exp_div_by_5, div_exp);
  endtask

  localparam logic [23:0] REMS_A5 = {3'd0, 3'd2, 3'd1, 3'd0, 3'd0, 3'd0, 3'd2, 3'd1};
  localparam logic [23:0] REMS_07 = {3'd2, 3'd3, 3'd1, 3'd0, 3'd0, 3'd0, 3'd0, 3'd0};

  initial begin
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;
    #12;
    chk("rst_rdy", in_ready, 1);
    chk("rst_vld", out_valid, 0);
    chk("rst_bit", new_bit, 0);
    chk("rst_first", first, 0);
    chk("rst_last", last, 0);
    chk("rst_rem", exp_rem, 0);
    chk("rst_div", exp_div_by_5, 1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    run_num(8'hA5, 8'b1010_0101, REMS_A5, 1'b1, -1, 0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    chk("hold_rem", exp_rem, 0);
    chk("hold_div", exp_div_by_5, 1);

    run_num(8'h07, 8'b0000_0111, REMS_07, 1'b0, -1, 0, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    chk("hold_rem7", exp_rem, 2);
    chk("hold_vld7", out_valid, 0);

    run_num(8'hA5, 8'b1010_0101, REMS_A5, 1'b1, 5, 3, 1'b0, 8'h00);
    @(negedge clk);

    // in_valid held across both numbers; in_data changes mid-flight and must be ignored
    run_num(8'h07, 8'b0000_0111, REMS_07, 1'b0, -1, 0, 1'b1, 8'hA5);
    run_num(8'hA5, 8'b1010_0101, REMS_A5, 1'b1, -1, 0, 1'b0, 8'h00);
    @(negedge clk);

    // abort mid-number with an asynchronous reset between clock edges
    in_valid = 1'b1;
    in_data  = 8'hA5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(negedge clk);
    chk("pre_abort_vld", out_valid, 1);
    chk("pre_abort_rem", exp_rem, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("abort_vld", out_valid, 0);
    chk("abort_rdy", in_ready, 1);
    chk("abort_bit", new_bit, 0);
    chk("abort_first", first, 0);
    chk("abort_last", last, 0);
    chk("abort_rem", exp_rem, 0);
    chk("abort_div", exp_div_by_5, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      chk("post_abort_vld", out_valid, 0);
    end

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
